// File: rtl/ace_loader_pkg.sv
// Shared types and constants for the Jupiter Ace .ACE snapshot loader.
package ace_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        LIT,
        CNT,
        RUNDAT,
        WRITE,
        FILL,
        END
    } state_t;

    localparam logic [7:0]  ACE_ESC      = 8'hED;
    localparam logic [15:0] ACE_RAM_BASE = 16'h2000;
    localparam logic [15:0] ACE_ADDR_TOP = 16'hFFFF;

endpackage

// File: rtl/ace_wr_port.sv
// Registered req/gnt write holder: keeps addr/data stable until granted,
// advances the address per grant and flags once the top address was written.
module ace_wr_port
    import ace_loader_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = ACE_RAM_BASE
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_init,
    input  logic        i_issue,
    input  logic        i_keep,
    input  logic [7:0]  i_data,
    input  logic        i_gnt,
    output logic        o_req,
    output logic [15:0] o_addr,
    output logic [7:0]  o_data,
    output logic        o_at_top,
    output logic        o_full
);

    logic        r_req;
    logic [15:0] r_addr;
    logic [7:0]  r_data;
    logic        r_full;
    logic        w_at_top;

    assign w_at_top = (r_addr == ACE_ADDR_TOP);

    // The address never wraps: a grant at the top only marks the port full.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_init) begin
            r_req  <= 1'b0;
            r_addr <= BASE_ADDR;
            r_data <= 8'h00;
            r_full <= 1'b0;
        end else if (r_req && i_gnt) begin
            r_req <= i_keep & ~w_at_top;
            if (w_at_top) begin
                r_full <= 1'b1;
            end else begin
                r_addr <= r_addr + 16'd1;
            end
        end else if (i_issue) begin
            r_req  <= 1'b1;
            r_data <= i_data;
        end
    end

    assign o_req    = r_req;
    assign o_addr   = r_addr;
    assign o_data   = r_data;
    assign o_at_top = w_at_top;
    assign o_full   = r_full;

endmodule

// File: rtl/ace_tap_loader.sv
// Expands an ED-escaped .ACE stream from the HPS ioctl channel into Jupiter
// Ace RAM, stalling the stream with ioctl_wait while writes are outstanding.
module ace_tap_loader
    import ace_loader_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR  = ACE_RAM_BASE,
    parameter logic [7:0]  ESC        = ACE_ESC,
    parameter int unsigned RST_CYCLES = 4
) (
    input  logic        i_clk_sys,
    input  logic        i_reset,
    input  logic        i_ioctl_download,
    input  logic [7:0]  i_ioctl_index,
    input  logic        i_ioctl_wr,
    input  logic [7:0]  i_ioctl_dout,
    output logic        o_ioctl_wait,
    output logic        o_cpu_reset,
    output logic        o_mem_req,
    input  logic        i_mem_gnt,
    output logic [15:0] o_mem_addr,
    output logic [7:0]  o_mem_data,
    output logic        o_busy,
    output logic        o_err
);

    localparam logic [7:0] RST_LAST = 8'(RST_CYCLES - 1);

    state_t      r_state;
    state_t      w_next;
    logic        r_dl_d;
    logic        r_wait;
    logic        r_cpu_reset;
    logic        r_busy;
    logic        r_err;
    logic [7:0]  r_cnt;
    logic [7:0]  r_rst_cnt;

    logic        w_rise;
    logic        w_wr;
    logic        w_gnt;
    logic        w_esc;
    logic        w_dl;
    logic        w_req;
    logic        w_full;
    logic        w_at_top;
    logic        w_ovf;
    logic        w_init;
    logic        w_issue;
    logic        w_keep;
    logic        w_wait_nxt;
    logic        w_cpu_reset_nxt;
    logic        w_busy_nxt;
    logic        w_err_nxt;
    logic [15:0] w_addr;
    logic [7:0]  w_data;

    assign w_dl   = i_ioctl_download;
    assign w_rise = i_ioctl_download & ~r_dl_d;
    assign w_wr   = i_ioctl_wr & ~r_wait;
    assign w_gnt  = w_req & i_mem_gnt;
    assign w_esc  = (i_ioctl_dout == ESC);

    // A write that would have to follow address FFFF is refused instead of issued.
    assign w_ovf = (w_dl & w_wr & w_full & (((r_state == LIT) & ~w_esc) | (r_state == RUNDAT)))
                 | ((r_state == FILL) & w_gnt & (r_cnt != 8'd1) & w_at_top);

    // State register, counters and registered outputs.
    always_ff @(posedge i_clk_sys) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_dl_d      <= 1'b1;
            r_wait      <= 1'b0;
            r_cpu_reset <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_cnt       <= 8'd0;
            r_rst_cnt   <= 8'd0;
        end else begin
            r_state     <= w_next;
            r_dl_d      <= i_ioctl_download;
            r_wait      <= w_wait_nxt;
            r_cpu_reset <= w_cpu_reset_nxt;
            r_busy      <= w_busy_nxt;
            r_err       <= w_err_nxt;
            r_rst_cnt   <= (r_state == START) ? r_rst_cnt + 8'd1 : 8'd0;
            if ((r_state == CNT) && (w_next == RUNDAT)) begin
                r_cnt <= i_ioctl_dout;
            end else if ((r_state == FILL) && w_gnt) begin
                r_cnt <= r_cnt - 8'd1;
            end
        end
    end

    // Next-state decode; pending writes always complete before IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = (w_rise && (i_ioctl_index != 8'd0)) ? START : IDLE;
            START:   w_next = (r_rst_cnt == RST_LAST) ? LIT : START;
            LIT: begin
                if (!w_dl)        w_next = IDLE;
                else if (!w_wr)   w_next = LIT;
                else if (w_esc)   w_next = CNT;
                else if (w_full)  w_next = END;
                else              w_next = WRITE;
            end
            CNT: begin
                if (!w_dl)                        w_next = IDLE;
                else if (!w_wr)                   w_next = CNT;
                else if (i_ioctl_dout == 8'd0)    w_next = END;
                else                              w_next = RUNDAT;
            end
            RUNDAT: begin
                if (!w_dl)        w_next = IDLE;
                else if (!w_wr)   w_next = RUNDAT;
                else if (w_full)  w_next = END;
                else              w_next = FILL;
            end
            WRITE:   w_next = !w_gnt ? WRITE : (w_dl ? LIT : IDLE);
            FILL: begin
                if (!w_gnt)               w_next = FILL;
                else if (r_cnt == 8'd1)   w_next = w_dl ? LIT : IDLE;
                else if (w_at_top)        w_next = w_dl ? END : IDLE;
                else                      w_next = FILL;
            end
            END:     w_next = w_dl ? END : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Next values of the registered outputs and write-port controls.
    always_comb begin
        w_init          = (r_state == IDLE) && (w_next == START);
        w_issue         = ((r_state == LIT) && (w_next == WRITE))
                       || ((r_state == RUNDAT) && (w_next == FILL));
        w_keep          = (r_state == FILL) && (r_cnt != 8'd1);
        w_wait_nxt      = (w_next == START) || (w_next == WRITE) || (w_next == FILL);
        w_cpu_reset_nxt = (w_next == START);
        w_busy_nxt      = (w_next != IDLE);
        if (w_init) begin
            w_err_nxt = 1'b0;
        end else if (((r_state == CNT) || (r_state == RUNDAT)) && !w_dl) begin
            w_err_nxt = 1'b1;
        end else if (w_ovf) begin
            w_err_nxt = 1'b1;
        end else begin
            w_err_nxt = r_err;
        end
    end

    ace_wr_port #(
        .BASE_ADDR (BASE_ADDR)
    ) u_wr_port (
        .i_clk    (i_clk_sys),
        .i_reset  (i_reset),
        .i_init   (w_init),
        .i_issue  (w_issue),
        .i_keep   (w_keep),
        .i_data   (i_ioctl_dout),
        .i_gnt    (i_mem_gnt),
        .o_req    (w_req),
        .o_addr   (w_addr),
        .o_data   (w_data),
        .o_at_top (w_at_top),
        .o_full   (w_full)
    );

    assign o_ioctl_wait = r_wait;
    assign o_cpu_reset  = r_cpu_reset;
    assign o_mem_req    = w_req;
    assign o_mem_addr   = w_addr;
    assign o_mem_data   = w_data;
    assign o_busy       = r_busy;
    assign o_err        = r_err;

endmodule

// File: tb/tb_ace_tap_loader.sv
// Directed bench for ace_tap_loader: a stream decoder model predicts the RAM
// writes and error flag, and a per-cycle monitor checks every granted write.
module tb_ace_tap_loader;

    localparam logic [15:0] BASE = 16'h2000;
    localparam logic [7:0]  ESC  = 8'hED;

    logic        clk = 1'b0;
    logic        reset;
    logic        download;
    logic [7:0]  idx;
    logic        ioctl_wr;
    logic [7:0]  dout;
    logic        ioctl_wait;
    logic        cpu_reset;
    logic        mem_req;
    logic        mem_gnt;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;
    logic        busy;
    logic        err;

    always #5 clk = ~clk;

    ace_tap_loader dut (
        .i_clk_sys        (clk),
        .i_reset          (reset),
        .i_ioctl_download (download),
        .i_ioctl_index    (idx),
        .i_ioctl_wr       (ioctl_wr),
        .i_ioctl_dout     (dout),
        .o_ioctl_wait     (ioctl_wait),
        .o_cpu_reset      (cpu_reset),
        .o_mem_req        (mem_req),
        .i_mem_gnt        (mem_gnt),
        .o_mem_addr       (mem_addr),
        .o_mem_data       (mem_data),
        .o_busy           (busy),
        .o_err            (err)
    );

    int          total = 0;
    int          bad   = 0;
    logic [23:0] exp_q[$];
    logic [23:0] act_q[$];
    logic [7:0]  stream[$];
    logic        exp_err;
    int          m_addr;
    bit          m_stop;
    int          rst_hi, wait_hi, busy_seen, grants, stall_left;
    bit          stall_arm, prev_stall;
    logic [15:0] prev_addr;
    logic [7:0]  prev_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out", name);
    endtask

    // One clock; decides the grant for this cycle and checks every write.
    task automatic tick();
        logic [23:0] e;
        @(posedge clk);
        #1;
        if (stall_arm && mem_req) begin
            stall_arm  = 1'b0;
            stall_left = 10;
        end
        mem_gnt = (stall_left == 0);
        if (stall_left > 0) stall_left--;
        if (cpu_reset)  rst_hi++;
        if (ioctl_wait) wait_hi++;
        if (busy)       busy_seen++;
        if (prev_stall && mem_req) begin
            check("stall_addr_stable", 32'(mem_addr), 32'(prev_addr));
            check("stall_data_stable", 32'(mem_data), 32'(prev_data));
        end
        if (mem_req) check("wait_while_req", 32'(ioctl_wait), 32'd1);
        if (mem_req && mem_gnt) begin
            grants++;
            act_q.push_back({mem_addr, mem_data});
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none",
                         mem_addr, mem_data);
            end else begin
                e = exp_q.pop_front();
                check("write", 32'({mem_addr, mem_data}), 32'(e));
            end
        end
        prev_stall = mem_req && !mem_gnt;
        prev_addr  = mem_addr;
        prev_data  = mem_data;
    endtask

    task automatic emit(input logic [7:0] d);
        if (m_addr > 32'h0000FFFF) begin
            exp_err = 1'b1;
            m_stop  = 1'b1;
        end else begin
            exp_q.push_back({m_addr[15:0], d});
            m_addr++;
        end
    endtask

    // Decodes a whole stream into the list of RAM writes and the final error flag.
    task automatic model(input logic [7:0] s[$]);
        int i;
        m_addr  = 32'(BASE);
        m_stop  = 1'b0;
        exp_err = 1'b0;
        i = 0;
        while ((i < s.size()) && !m_stop) begin
            if (s[i] != ESC) begin
                emit(s[i]);
                i++;
            end else if (i + 1 >= s.size()) begin
                exp_err = 1'b1;
                m_stop  = 1'b1;
            end else if (s[i+1] == 8'd0) begin
                m_stop = 1'b1;
            end else if (i + 2 >= s.size()) begin
                exp_err = 1'b1;
                m_stop  = 1'b1;
            end else begin
                for (int k = 0; (k < int'(s[i+1])) && !m_stop; k++) emit(s[i+2]);
                i += 3;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        while (ioctl_wait && (n < 1000)) begin
            tick();
            n++;
        end
        if (n >= 1000) timeout("send_byte_wait");
        dout     = b;
        ioctl_wr = 1'b1;
        tick();
        ioctl_wr = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && (n < 2000)) begin
            tick();
            n++;
        end
        if (n >= 2000) timeout("busy_fall");
        repeat (3) tick();
    endtask

    task automatic start_test();
        exp_q.delete();
        act_q.delete();
        rst_hi    = 0;
        wait_hi   = 0;
        busy_seen = 0;
        grants    = 0;
    endtask

    task automatic run_load(input logic [7:0] id, input bit spurious, input bit drop);
        start_test();
        if (id != 8'd0) model(stream);
        idx      = id;
        download = 1'b1;
        tick();
        foreach (stream[i]) send_byte(stream[i]);
        if (spurious && ioctl_wait) begin
            dout     = 8'h99;
            ioctl_wr = 1'b1;
            tick();
            ioctl_wr = 1'b0;
        end
        if (drop) begin
            download = 1'b0;
            wait_idle();
        end
    endtask

    task automatic end_checks(input string name);
        check({name, "_missing_writes"}, 32'(exp_q.size()), 32'd0);
        check({name, "_err"}, 32'(err), 32'(exp_err));
        check({name, "_busy_after_drop"}, 32'(busy), 32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        download   = 1'b0;
        idx        = 8'd0;
        ioctl_wr   = 1'b0;
        dout       = 8'd0;
        mem_gnt    = 1'b1;
        stall_left = 0;
        stall_arm  = 1'b0;
        prev_stall = 1'b0;
        start_test();
        repeat (3) tick();
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_wait", 32'(ioctl_wait), 32'd0);
        check("rst_cpu_reset", 32'(cpu_reset), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'h2000);
        check("rst_data", 32'(mem_data), 32'd0);
        reset = 1'b0;
        repeat (2) tick();

        // Plain literals
        stream = '{8'h11, 8'h22, 8'h33};
        run_load(8'd1, 1'b0, 1'b1);
        end_checks("lit");
        check("lit_count", 32'(act_q.size()), 32'd3);
        check("lit_first", 32'(act_q[0]), 32'h200011);
        check("lit_last", 32'(act_q[2]), 32'h200233);
        check("lit_cpu_reset_cycles", 32'(rst_hi), 32'd4);

        // Run of five, with a strobe sent while stalled
        stream = '{8'hED, 8'h05, 8'hAA};
        run_load(8'd1, 1'b1, 1'b1);
        end_checks("run");
        check("run_count", 32'(act_q.size()), 32'd5);
        check("run_last", 32'(act_q[4]), 32'h2004AA);
        check("run_wait_cycles", 32'(wait_hi), 32'd9);

        // Stop marker
        stream = '{8'h01, 8'hED, 8'h00, 8'h02, 8'h03};
        run_load(8'd1, 1'b0, 1'b1);
        end_checks("stop");
        check("stop_count", 32'(act_q.size()), 32'd1);
        check("stop_first", 32'(act_q[0]), 32'h200001);

        // Grant stalled 10 cycles during a run
        stream    = '{8'hED, 8'h03, 8'h77};
        stall_arm = 1'b1;
        run_load(8'd1, 1'b0, 1'b1);
        end_checks("stall");
        check("stall_count", 32'(act_q.size()), 32'd3);
        check("stall_first", 32'(act_q[0]), 32'h200077);
        check("stall_wait_cycles", 32'(wait_hi), 32'd17);

        // Truncated escape, in both CNT and RUNDAT
        stream = '{8'h12, 8'hED, 8'h05};
        run_load(8'd1, 1'b0, 1'b1);
        end_checks("trunc_rundat");
        stream = '{8'hED};
        run_load(8'd1, 1'b0, 1'b1);
        end_checks("trunc_cnt");
        check("trunc_err_literal", 32'(err), 32'd1);

        // Index 0 is ignored entirely
        stream = '{8'h11, 8'h22};
        run_load(8'd0, 1'b0, 1'b1);
        check("idx0_busy_seen", 32'(busy_seen), 32'd0);
        check("idx0_cpu_reset", 32'(rst_hi), 32'd0);
        check("idx0_writes", 32'(act_q.size()), 32'd0);
        check("idx0_err_kept", 32'(err), 32'd1);

        // Address overflow through long runs
        stream.delete();
        for (int r = 0; r < 224; r++) begin
            stream.push_back(8'hED);
            stream.push_back(8'hFF);
            stream.push_back(8'(r));
        end
        stream.push_back(8'hED);
        stream.push_back(8'hFF);
        stream.push_back(8'hC3);
        stream.push_back(8'h11);
        run_load(8'd1, 1'b0, 1'b0);
        repeat (5) tick();
        check("ovf_model_err", 32'(exp_err), 32'd1);
        check("ovf_err", 32'(err), 32'(exp_err));
        check("ovf_busy_in_end", 32'(busy), 32'd1);
        check("ovf_missing_writes", 32'(exp_q.size()), 32'd0);
        check("ovf_count", 32'(act_q.size()), 32'd57344);
        check("ovf_last", 32'(act_q[act_q.size() - 1]), 32'hFFFFC3);
        download = 1'b0;
        wait_idle();
        check("ovf_busy_after_drop", 32'(busy), 32'd0);

        // Reset in the middle of a run of 16
        start_test();
        exp_q.push_back(24'h200055);
        exp_q.push_back(24'h200155);
        exp_q.push_back(24'h200255);
        idx      = 8'd1;
        download = 1'b1;
        tick();
        send_byte(8'hED);
        send_byte(8'h10);
        send_byte(8'h55);
        begin
            int n = 0;
            while ((grants < 3) && (n < 200)) begin
                tick();
                n++;
            end
            if (n >= 200) timeout("grants_before_reset");
        end
        reset    = 1'b1;
        download = 1'b0;
        tick();
        check("mrst_req", 32'(mem_req), 32'd0);
        check("mrst_wait", 32'(ioctl_wait), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_err", 32'(err), 32'd0);
        check("mrst_addr", 32'(mem_addr), 32'h2000);
        reset     = 1'b0;
        busy_seen = 0;
        repeat (20) tick();
        check("mrst_busy_seen", 32'(busy_seen), 32'd0);
        check("mrst_count", 32'(act_q.size()), 32'd3);
        check("mrst_missing_writes", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
